// File: rtl/axi4_rd_arbiter_if.sv
// AXI4 bus bundle shared by the read arbiter and its downstream slave.
// The master modport drives AR/AW/W and the ready signals of R/B.
interface axi4 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter merging NUM_REQ read requesters onto one AXI4 read port.
// ARID carries the requester index so R beats route back with zero latency.
module axi4_rd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    output logic [NUM_REQ-1:0]            err_flags,
    axi4.master                           m_axi
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 4;
    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [IDX_W-1:0]      r_last_grant;
    logic [NUM_REQ-1:0]    r_err;

    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_req_fire;
    logic [NUM_REQ-1:0]    w_rid_hit;
    logic [NUM_REQ-1:0]    w_beat_fire;
    logic                  w_slot_free;
    logic                  w_found;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [IDX_W-1:0]      w_rr_start;
    logic                  w_rid_known;
    logic                  w_unused_ok;

    // Slot may be reloaded in the same cycle the current AR is taken.
    assign w_slot_free = !r_arvalid || m_axi.arready;
    assign w_rr_start  = (r_last_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_last_grant + 1'b1;

    always_comb begin
        logic [IDX_W:0] v_idx;
        w_found     = 1'b0;
        w_grant_idx = '0;
        v_idx       = '0;
        // Walk from lowest priority to highest so the highest-priority hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = {1'b0, w_rr_start} + (IDX_W + 1)'(k);
            if (v_idx >= (IDX_W + 1)'(NUM_REQ)) begin
                v_idx = v_idx - (IDX_W + 1)'(NUM_REQ);
            end
            if (w_elig[v_idx[IDX_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = v_idx[IDX_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [CNT_W-1:0] r_cnt;
            logic             w_dec;

            assign w_elig[gi]     = req_valid[gi] && (r_cnt < CNT_W'(MAX_OUTSTANDING));
            assign req_ready[gi]  = !areset && w_slot_free && w_found && (w_grant_idx == IDX_W'(gi));
            assign w_req_fire[gi] = req_valid[gi] && req_ready[gi];

            assign w_rid_hit[gi]   = (m_axi.rid == ID_WIDTH'(gi));
            assign rsp_valid[gi]   = m_axi.rvalid && w_rid_hit[gi];
            assign w_beat_fire[gi] = rsp_valid[gi] && m_axi.rready;
            // A stray RLAST with nothing outstanding is routed but not counted.
            assign w_dec = w_beat_fire[gi] && m_axi.rlast && (r_cnt != '0);

            always_ff @(posedge aclk) begin
                if (areset) begin
                    r_cnt <= '0;
                end else if (w_req_fire[gi] && !w_dec) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!w_req_fire[gi] && w_dec) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arid       <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (|w_req_fire) begin
            r_arvalid    <= 1'b1;
            r_araddr     <= req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_arlen      <= req_len[w_grant_idx*8 +: 8];
            r_arid       <= ID_WIDTH'(w_grant_idx);
            r_last_grant <= w_grant_idx;
        end else if (m_axi.arready) begin
            r_arvalid    <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err <= '0;
        end else if (m_axi.rresp != 2'b00) begin
            r_err <= r_err | w_beat_fire;
        end
    end

    // Out-of-range IDs are sunk so a misrouted beat cannot stall the bus.
    assign w_rid_known  = |w_rid_hit;
    assign m_axi.rready = !w_rid_known || (|(rsp_ready & w_rid_hit));
    assign rsp_data     = m_axi.rdata;
    assign rsp_last     = m_axi.rlast;
    assign err_flags    = r_err;

    assign m_axi.arvalid  = r_arvalid;
    assign m_axi.araddr   = r_araddr;
    assign m_axi.arlen    = r_arlen;
    assign m_axi.arid     = r_arid;
    assign m_axi.arsize   = AR_SIZE;
    assign m_axi.arburst  = 2'b01;
    assign m_axi.arcache  = 4'b0011;
    assign m_axi.arlock   = 1'b0;
    assign m_axi.arprot   = 3'b000;
    assign m_axi.arqos    = 4'b0000;
    assign m_axi.arregion = 4'b0000;

    assign m_axi.awid     = '0;
    assign m_axi.awaddr   = '0;
    assign m_axi.awlen    = '0;
    assign m_axi.awsize   = '0;
    assign m_axi.awburst  = '0;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = '0;
    assign m_axi.awprot   = '0;
    assign m_axi.awqos    = '0;
    assign m_axi.awregion = '0;
    assign m_axi.awvalid  = 1'b0;
    assign m_axi.wdata    = '0;
    assign m_axi.wstrb    = '0;
    assign m_axi.wlast    = 1'b0;
    assign m_axi.wvalid   = 1'b0;
    assign m_axi.bready   = 1'b1;

    assign w_unused_ok = ^{m_axi.awready, m_axi.wready, m_axi.bid, m_axi.bresp, m_axi.bvalid};
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter: a vector table for single-cycle behaviour
// followed by hand-written sequences for stall, reset and outstanding limits.
module tb_axi4_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MO = 4;
    localparam int NV = 15;

    logic             aclk = 1'b0;
    logic             areset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*AW-1:0]  req_addr;
    logic [N*8-1:0]   req_len;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic             rsp_last;
    logic [N-1:0]     err_flags;

    axi4 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi_bus ();

    axi4_rd_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .err_flags(err_flags),
        .m_axi(axi_bus)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  rv;
        logic        arr;
        logic        rvalid;
        logic [3:0]  rid;
        logic [1:0]  rresp;
        logic        rlast;
        logic [3:0]  rsrdy;
        logic [3:0]  e_rrdy;
        logic        e_arv;
        logic [3:0]  e_arid;
        logic [31:0] e_araddr;
        logic [7:0]  e_arlen;
        logic [3:0]  e_rspv;
        logic        e_rready;
        logic [3:0]  e_err;
    } vec_t;

    vec_t vec [NV];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_r(input logic v, input logic [3:0] id, input logic [1:0] resp, input logic last);
        axi_bus.rvalid = v;
        axi_bus.rid    = id;
        axi_bus.rresp  = resp;
        axi_bus.rlast  = last;
    endtask

    initial begin
        // Single-burst read, round-robin sweep, then error and out-of-range R beats.
        vec[0]  = '{4'b0001,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b0001,1'b0,4'd0,32'h0,   8'd0,4'b0000,1'b1,4'b0000};
        vec[1]  = '{4'b0000,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b0000,1'b1,4'd0,32'h1000,8'd3,4'b0000,1'b1,4'b0000};
        vec[2]  = '{4'b0000,1'b1,1'b1,4'd0,2'd0,1'b0,4'b1111, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0001,1'b1,4'b0000};
        vec[3]  = '{4'b0000,1'b1,1'b1,4'd0,2'd0,1'b0,4'b1111, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0001,1'b1,4'b0000};
        vec[4]  = '{4'b0000,1'b1,1'b1,4'd0,2'd0,1'b0,4'b1111, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0001,1'b1,4'b0000};
        vec[5]  = '{4'b0000,1'b1,1'b1,4'd0,2'd0,1'b1,4'b1111, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0001,1'b1,4'b0000};
        vec[6]  = '{4'b1111,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b0010,1'b0,4'd0,32'h0,   8'd0,4'b0000,1'b1,4'b0000};
        vec[7]  = '{4'b1111,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b0100,1'b1,4'd1,32'h2000,8'd4,4'b0000,1'b1,4'b0000};
        vec[8]  = '{4'b1111,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b1000,1'b1,4'd2,32'h3000,8'd5,4'b0000,1'b1,4'b0000};
        vec[9]  = '{4'b1111,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b0001,1'b1,4'd3,32'h4000,8'd6,4'b0000,1'b1,4'b0000};
        vec[10] = '{4'b0000,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b0000,1'b1,4'd0,32'h1000,8'd3,4'b0000,1'b1,4'b0000};
        vec[11] = '{4'b0000,1'b1,1'b1,4'd1,2'd2,1'b0,4'b1111, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0010,1'b1,4'b0000};
        vec[12] = '{4'b0000,1'b1,1'b1,4'd7,2'd2,1'b1,4'b0000, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0000,1'b1,4'b0010};
        vec[13] = '{4'b0000,1'b1,1'b1,4'd2,2'd3,1'b0,4'b1011, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0100,1'b0,4'b0010};
        vec[14] = '{4'b0000,1'b1,1'b0,4'd0,2'd0,1'b0,4'b1111, 4'b0000,1'b0,4'd0,32'h0,   8'd0,4'b0000,1'b1,4'b0010};

        req_addr = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        req_len  = {8'd6, 8'd5, 8'd4, 8'd3};
        req_valid = '0;
        rsp_ready = '1;
        axi_bus.arready = 1'b0;
        axi_bus.rdata   = '0;
        set_r(1'b0, 4'd0, 2'd0, 1'b0);
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bid     = '0;
        axi_bus.bresp   = '0;
        axi_bus.bvalid  = 1'b0;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("reset arvalid", 64'(axi_bus.arvalid), 64'd0);
        chk("reset err_flags", 64'(err_flags), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("arsize", 64'(axi_bus.arsize), 64'd2);
        chk("arburst", 64'(axi_bus.arburst), 64'd1);
        chk("arcache", 64'(axi_bus.arcache), 64'd3);
        chk("aw/w tie-off", 64'({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}), 64'b001);

        for (int i = 0; i < NV; i++) begin
            @(negedge aclk);
            req_valid       = vec[i].rv;
            axi_bus.arready = vec[i].arr;
            rsp_ready       = vec[i].rsrdy;
            axi_bus.rdata   = 32'hD000_0000 + 32'(i);
            set_r(vec[i].rvalid, vec[i].rid, vec[i].rresp, vec[i].rlast);
            #1;
            $display("vec %0d: req_valid=%b req_ready=%b arvalid=%b arid=%0d rsp_valid=%b rready=%b err=%b",
                     i, req_valid, req_ready, axi_bus.arvalid, axi_bus.arid, rsp_valid, axi_bus.rready, err_flags);
            chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vec[i].e_rrdy));
            chk($sformatf("v%0d arvalid", i), 64'(axi_bus.arvalid), 64'(vec[i].e_arv));
            if (vec[i].e_arv) begin
                chk($sformatf("v%0d arid", i), 64'(axi_bus.arid), 64'(vec[i].e_arid));
                chk($sformatf("v%0d araddr", i), 64'(axi_bus.araddr), 64'(vec[i].e_araddr));
                chk($sformatf("v%0d arlen", i), 64'(axi_bus.arlen), 64'(vec[i].e_arlen));
            end
            chk($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'(vec[i].e_rspv));
            chk($sformatf("v%0d rready", i), 64'(axi_bus.rready), 64'(vec[i].e_rready));
            chk($sformatf("v%0d err_flags", i), 64'(err_flags), 64'(vec[i].e_err));
            chk($sformatf("v%0d rsp_last", i), 64'(rsp_last), 64'(vec[i].rlast));
            chk($sformatf("v%0d rsp_data", i), 64'(rsp_data), 64'(32'hD000_0000 + 32'(i)));
        end

        // AR stall: slot held with stable fields while ARREADY stays low.
        @(negedge aclk);
        req_valid = 4'b0100;
        axi_bus.arready = 1'b0;
        rsp_ready = '1;
        set_r(1'b0, 4'd0, 2'd0, 1'b0);
        #1;
        chk("stall load req_ready", 64'(req_ready), 64'b0100);
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            req_valid = 4'b1111;
            #1;
            $display("stall %0d: arvalid=%b arid=%0d araddr=%h arlen=%0d req_ready=%b",
                     c, axi_bus.arvalid, axi_bus.arid, axi_bus.araddr, axi_bus.arlen, req_ready);
            chk($sformatf("stall%0d arvalid", c), 64'(axi_bus.arvalid), 64'd1);
            chk($sformatf("stall%0d arid", c), 64'(axi_bus.arid), 64'd2);
            chk($sformatf("stall%0d araddr", c), 64'(axi_bus.araddr), 64'h3000);
            chk($sformatf("stall%0d arlen", c), 64'(axi_bus.arlen), 64'd5);
            chk($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'd0);
        end

        // Reset mid-operation: pending AR dropped, flags cleared, index 0 favoured.
        @(negedge aclk);
        areset = 1'b1;
        axi_bus.arready = 1'b1;
        #1;
        chk("in-reset req_ready", 64'(req_ready), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        $display("post-reset: arvalid=%b err=%b req_ready=%b", axi_bus.arvalid, err_flags, req_ready);
        chk("post-reset arvalid", 64'(axi_bus.arvalid), 64'd0);
        chk("post-reset err_flags", 64'(err_flags), 64'd0);
        chk("post-reset grant", 64'(req_ready), 64'b0001);

        // Outstanding limit on requester 2, released by one RLAST.
        @(negedge aclk);
        req_valid = 4'b0100;
        #1;
        chk("post-reset arid", 64'(axi_bus.arid), 64'd0);
        chk("post-reset araddr", 64'(axi_bus.araddr), 64'h1000);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                @(negedge aclk);
                #1;
            end
            $display("limit req2 #%0d: req_ready=%b", k, req_ready);
            chk($sformatf("limit%0d req_ready", k), 64'(req_ready), 64'b0100);
        end
        @(negedge aclk);
        set_r(1'b1, 4'd2, 2'd0, 1'b1);
        #1;
        $display("limit req2 full: req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
        chk("limit full req_ready", 64'(req_ready), 64'd0);
        chk("limit rlast rsp_valid", 64'(rsp_valid), 64'b0100);
        @(negedge aclk);
        set_r(1'b0, 4'd0, 2'd0, 1'b0);
        #1;
        chk("limit released req_ready", 64'(req_ready), 64'b0100);

        // Stray RLAST for an idle requester must not wrap its counter.
        @(negedge aclk);
        req_valid = 4'b0000;
        set_r(1'b1, 4'd3, 2'd0, 1'b1);
        @(negedge aclk);
        set_r(1'b0, 4'd0, 2'd0, 1'b0);
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                @(negedge aclk);
            end
            #1;
            $display("req3 #%0d: req_ready=%b", k, req_ready);
            chk($sformatf("req3 #%0d req_ready", k), 64'(req_ready), (k < 4) ? 64'b1000 : 64'd0);
        end
        chk("final err_flags", 64'(err_flags), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4_rd_arbiter.md
AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI4 address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, AXI4 data width (power of two, >=32).
REQ-004 SHALL have parameter ID_WIDTH, default 4, AXI4 ID width (>= clog2(NUM_REQ)).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight bursts per requester (1..15).
REQ-006 SHALL have port aclk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port areset  input  1  synchronous reset, active-high.
REQ-008 SHALL have port req_valid  input  NUM_REQ  per-requester command valid.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester command accept.
REQ-010 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  burst start address, requester i at slice i.
REQ-011 SHALL have port req_len  input  NUM_REQ*8  burst length minus one (AXI ARLEN encoding).
REQ-012 SHALL have port rsp_valid  output  NUM_REQ  read beat valid, one-hot or zero.
REQ-013 SHALL have port rsp_ready  input  NUM_REQ  per-requester beat accept.
REQ-014 SHALL have port rsp_data  output  DATA_WIDTH  shared read data (RDATA pass-through).
REQ-015 SHALL have port rsp_last  output  1  last beat of burst (RLAST pass-through).
REQ-016 SHALL have port err_flags  output  NUM_REQ  sticky per-requester RRESP error.
REQ-017 SHALL have port m_axi  axi4.master  --  shared downstream AXI4 port; read channels driven, write channels tied off.

Function
REQ-018 SHALL drive AWVALID, WVALID, all AW/W fields to 0 and BREADY to 1.
REQ-019 SHALL hold a single registered AR slot; ARVALID high until the ARREADY handshake, fields stable while ARVALID.
REQ-020 SHALL drive ARID = granted index, ARBURST = 2'b01, ARSIZE = log2(DATA_WIDTH/8), ARCACHE = 4'b0011, ARLOCK/ARPROT/ARQOS/ARREGION = 0.
REQ-021 SHALL treat requester i eligible when req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
REQ-022 SHALL grant round-robin: highest priority to index (last_grant+1) mod NUM_REQ; after reset, index 0 highest.
REQ-023 SHALL assert req_ready[i] combinationally only for the granted i and only when (ARVALID=0 or ARREADY=1); at most one bit high.
REQ-024 SHALL load the AR slot on the req handshake in cycle N, giving ARVALID=1 in cycle N+1 (back-to-back loads allowed when ARREADY=1).
REQ-025 SHALL keep per-requester outstanding counters: +1 on req handshake, -1 on R handshake with RLAST=1 and RID=i, unchanged if both same cycle.
REQ-026 SHALL route R: rsp_valid[RID]=RVALID, RREADY=rsp_ready[RID] for RID<NUM_REQ; no beat buffering, zero latency.
REQ-027 SHALL, for RID>=NUM_REQ, drive RREADY=1, rsp_valid=0, and discard the beat.
REQ-028 SHALL set err_flags[RID] on any R handshake with RRESP!=0; cleared only by reset.
REQ-029 SHALL never decrement a counter below 0; an RLAST for a requester with outstanding=0 is routed but counter stays 0.

Reset
REQ-030 SHALL, while areset=1 at a clock edge, clear ARVALID, AR fields, all counters, err_flags, and the round-robin pointer (index 0 highest).
REQ-031 SHALL hold req_ready=0 during reset cycles; rsp_valid and RREADY remain pure R-channel routing.
REQ-032 SHALL drop an in-flight AR (ARVALID cleared) on reset mid-operation without handshake completion.

Verification
REQ-033 SHALL be tested: req_valid=4'b0001, addr 0x1000, len 3, ARREADY=1 -> ARVALID one cycle after accept, ARADDR=0x1000, ARLEN=3, ARID=0; 4 R beats RID=0 appear on rsp_valid[0], rsp_last on beat 4.
REQ-034 SHALL be tested: req_valid=4'b1111 continuous, ARREADY=1 -> grant order 0,1,2,3,0,... one AR per cycle.
REQ-035 SHALL be tested: requester 2 issues 4 bursts, no R returned -> req_ready[2] stays 0 on 5th request; one RLAST RID=2 -> 5th accepted next eligible cycle.
REQ-036 SHALL be tested: ARREADY=0 for 10 cycles with ARVALID=1 -> ARADDR/ARID/ARLEN stable, req_ready all 0.
REQ-037 SHALL be tested: R beat RID=1 RRESP=2'b10 -> err_flags=4'b0010 persists; beat RID=7 -> RREADY=1, rsp_valid=0.
REQ-038 SHALL be tested: areset asserted with ARVALID=1 and counters nonzero -> next cycle ARVALID=0, counters 0, err_flags 0, next grant favours index 0.
